execute_stage: RTL and testbench

- Pipeline stage directly upstream of the memory stage.
- Holds the ID/EX pipeline register and computes the ALU result, zero flag, branch target and jump target.
- Produces every `*_e` signal that the memory stage consumes combinationally.
- Contains a multi-cycle multiply/divide unit with architectural HI/LO registers. This unit stalls the front end while it is busy.

---
 rtl/execute_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: ID/EX pipeline register, ALU, branch/jump target generation,
// and a multi-cycle multiply/divide unit that owns the HI/LO registers.
module execute_stage #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_stall,
  input  logic        reg_write_d,
  input  logic        mem_to_reg_d,
  input  logic        mem_write_d,
  input  logic        mem_access_d,
  input  logic        branch_d,
  input  logic        alu_src_d,
  input  logic [3:0]  branch_type_d,
  input  logic [3:0]  alu_ctrl_d,
  input  logic [2:0]  md_op_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [4:0]  shamt_d,
  input  logic [4:0]  write_reg_d,
  input  logic [25:0] instr_index_d,
  output logic        reg_write_e,
  output logic        mem_to_reg_e,
  output logic        mem_write_e,
  output logic        mem_access_e,
  output logic        branch_e,
  output logic [3:0]  branch_type_e,
  output logic [31:0] alu_out_e,
  output logic [31:0] write_data_e,
  output logic [31:0] pc_branch_e,
  output logic [31:0] jump_addr_e,
  output logic [4:0]  write_reg_e,
  output logic        zero_e,
  output logic        ex_busy,
  output logic [1:0]  md_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  // ID/EX pipeline register
  logic        reg_write_q, mem_to_reg_q, mem_write_q, mem_access_q, branch_q, alu_src_q;
  logic [3:0]  branch_type_q, alu_ctrl_q;
  logic [2:0]  md_op_q;
  logic [31:0] rd1_q, rd2_q, imm_q, pc_plus4_q;
  logic [4:0]  shamt_q, write_reg_q;
  logic [25:0] instr_index_q;

  logic advance;
  assign advance = !mem_stall && !ex_busy;

  always_ff @(posedge clk) begin
    if (rst || (advance && flush)) begin
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_access_q  <= 1'b0;
      branch_q      <= 1'b0;
      alu_src_q     <= 1'b0;
      branch_type_q <= 4'b0;
      alu_ctrl_q    <= 4'b0;
      md_op_q       <= 3'b0;
      rd1_q         <= 32'b0;
      rd2_q         <= 32'b0;
      imm_q         <= 32'b0;
      pc_plus4_q    <= 32'b0;
      shamt_q       <= 5'b0;
      write_reg_q   <= 5'b0;
      instr_index_q <= 26'b0;
    end else if (advance) begin
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      mem_write_q   <= mem_write_d;
      mem_access_q  <= mem_access_d;
      branch_q      <= branch_d;
      alu_src_q     <= alu_src_d;
      branch_type_q <= branch_type_d;
      alu_ctrl_q    <= alu_ctrl_d;
      md_op_q       <= md_op_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
      pc_plus4_q    <= pc_plus4_d;
      shamt_q       <= shamt_d;
      write_reg_q   <= write_reg_d;
      instr_index_q <= instr_index_d;
    end
  end

  // Multiply/divide unit
  logic [1:0]  state;
  logic [7:0]  count;
  logic        md_served;
  logic [31:0] hi, lo;
  logic [31:0] div_q, div_r, div_d, div_dividend;
  logic        div_neg_q, div_neg_r, div_zero;

  logic is_mul, is_div, md_start;
  assign is_mul   = (md_op_q == MD_MULT) || (md_op_q == MD_MULTU);
  assign is_div   = (md_op_q == MD_DIV) || (md_op_q == MD_DIVU);
  // md_served keeps a finished op that is still held in ID/EX (mem_stall) from restarting.
  assign md_start = (state == S_IDLE) && (is_mul || is_div) && !md_served;
  assign ex_busy  = md_start || (state == S_MUL) || (state == S_DIV);
  assign md_state = state;

  logic        a_neg, b_neg;
  logic [32:0] div_shift;
  logic        div_fit;
  logic [31:0] div_trial, div_q_next, div_r_next, quot_fix, rem_fix;
  logic [63:0] prod;

  assign a_neg = (md_op_q == MD_DIV) && rd1_q[31];
  assign b_neg = (md_op_q == MD_DIV) && rd2_q[31];

  always_comb begin
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    div_shift  = {div_r, div_q[31]};
    div_fit    = div_shift >= {1'b0, div_d};
    div_trial  = div_shift[31:0] - div_d;
    div_r_next = div_fit ? div_trial : div_shift[31:0];
    div_q_next = {div_q[30:0], div_fit};
    quot_fix   = div_neg_q ? (32'd0 - div_q_next) : div_q_next;
    rem_fix    = div_neg_r ? (32'd0 - div_r_next) : div_r_next;
    if (md_op_q == MD_MULT)
      prod = $signed({{32{rd1_q[31]}}, rd1_q}) * $signed({{32{rd2_q[31]}}, rd2_q});
    else
      prod = {32'b0, rd1_q} * {32'b0, rd2_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= 8'd0;
      md_served    <= 1'b0;
      hi           <= 32'b0;
      lo           <= 32'b0;
      div_q        <= 32'b0;
      div_r        <= 32'b0;
      div_d        <= 32'b0;
      div_dividend <= 32'b0;
      div_neg_q    <= 1'b0;
      div_neg_r    <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      if (advance) md_served <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_start && is_mul) begin
            state <= S_MUL;
            count <= 8'(MUL_CYCLES - 1);
          end else if (md_start) begin
            state        <= S_DIV;
            count        <= 8'd31;
            div_q        <= a_neg ? (32'd0 - rd1_q) : rd1_q;
            div_d        <= b_neg ? (32'd0 - rd2_q) : rd2_q;
            div_r        <= 32'b0;
            div_dividend <= rd1_q;
            div_neg_q    <= a_neg ^ b_neg;
            div_neg_r    <= a_neg;
            div_zero     <= (rd2_q == 32'b0);
          end else if (advance && md_op_q == MD_MTHI) begin
            hi <= rd1_q;
          end else if (advance && md_op_q == MD_MTLO) begin
            lo <= rd1_q;
          end
        end
        S_MUL: begin
          if (count == 8'd0) begin
            state     <= S_DONE;
            md_served <= 1'b1;
            hi        <= prod[63:32];
            lo        <= prod[31:0];
          end else begin
            count <= count - 8'd1;
          end
        end
        S_DIV: begin
          div_q <= div_q_next;
          div_r <= div_r_next;
          if (count == 8'd0) begin
            state     <= S_DONE;
            md_served <= 1'b1;
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= div_dividend;
            end else begin
              lo <= quot_fix;
              hi <= rem_fix;
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU
  logic [31:0] src_b;
  assign src_b = alu_src_q ? imm_q : rd2_q;

  always_comb begin
    case (alu_ctrl_q)
      4'b0000: alu_out_e = rd1_q & src_b;
      4'b0001: alu_out_e = rd1_q | src_b;
      4'b0010: alu_out_e = rd1_q + src_b;
      4'b0011: alu_out_e = rd1_q ^ src_b;
      4'b0100: alu_out_e = ~(rd1_q | src_b);
      4'b0110: alu_out_e = rd1_q - src_b;
      4'b0111: alu_out_e = {31'b0, $signed(rd1_q) < $signed(src_b)};
      4'b1000: alu_out_e = {31'b0, rd1_q < src_b};
      4'b1001: alu_out_e = src_b << shamt_q;
      4'b1010: alu_out_e = src_b >> shamt_q;
      4'b1011: alu_out_e = $signed(src_b) >>> shamt_q;
      4'b1100: alu_out_e = {imm_q[15:0], 16'b0};
      4'b1101: alu_out_e = hi;
      4'b1110: alu_out_e = lo;
      default: alu_out_e = 32'b0;
    endcase
  end

  assign zero_e       = (alu_out_e == 32'b0);
  assign write_data_e = rd2_q;
  assign pc_branch_e  = pc_plus4_q + {imm_q[29:0], 2'b00};
  assign jump_addr_e  = {pc_plus4_q[31:28], instr_index_q, 2'b00};
  assign write_reg_e  = write_reg_q;
  assign mem_to_reg_e = mem_to_reg_q;

  // Side-effecting controls are masked while the MD unit holds the instruction.
  assign reg_write_e   = reg_write_q && !ex_busy;
  assign mem_write_e   = mem_write_q && !ex_busy;
  assign mem_access_e  = mem_access_q && !ex_busy;
  assign branch_e      = branch_q && !ex_busy;
  assign branch_type_e = ex_busy ? 4'b0000 : branch_type_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a driver queues expected outputs after
// each clock and a negedge monitor pops and compares them.
module tb_execute_stage;
  localparam int MUL_CYC = 3;

  localparam int SEL_ALU = 0, SEL_ZERO = 1, SEL_PCB = 2, SEL_JMP = 3, SEL_BUSY = 4;
  localparam int SEL_RW = 5, SEL_MTR = 6, SEL_MW = 7, SEL_MA = 8, SEL_BR = 9;
  localparam int SEL_BT = 10, SEL_WR = 11, SEL_WD = 12, SEL_ST = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, mem_stall;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, mem_access_d, branch_d, alu_src_d;
  logic [3:0]  branch_type_d, alu_ctrl_d;
  logic [2:0]  md_op_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_plus4_d;
  logic [4:0]  shamt_d, write_reg_d;
  logic [25:0] instr_index_d;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e;
  logic [3:0]  branch_type_e;
  logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
  logic [4:0]  write_reg_e;
  logic        zero_e, ex_busy;
  logic [1:0]  md_state;

  execute_stage #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_stall(mem_stall),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .mem_access_d(mem_access_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
    .branch_type_d(branch_type_d), .alu_ctrl_d(alu_ctrl_d), .md_op_d(md_op_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_plus4_d(pc_plus4_d),
    .shamt_d(shamt_d), .write_reg_d(write_reg_d), .instr_index_d(instr_index_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .mem_access_e(mem_access_e), .branch_e(branch_e), .branch_type_e(branch_type_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .pc_branch_e(pc_branch_e),
    .jump_addr_e(jump_addr_e), .write_reg_e(write_reg_e), .zero_e(zero_e),
    .ex_busy(ex_busy), .md_state(md_state)
  );

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      SEL_ALU:  return alu_out_e;
      SEL_ZERO: return {31'b0, zero_e};
      SEL_PCB:  return pc_branch_e;
      SEL_JMP:  return jump_addr_e;
      SEL_BUSY: return {31'b0, ex_busy};
      SEL_RW:   return {31'b0, reg_write_e};
      SEL_MTR:  return {31'b0, mem_to_reg_e};
      SEL_MW:   return {31'b0, mem_write_e};
      SEL_MA:   return {31'b0, mem_access_e};
      SEL_BR:   return {31'b0, branch_e};
      SEL_BT:   return {28'b0, branch_type_e};
      SEL_WR:   return {27'b0, write_reg_e};
      SEL_WD:   return write_data_e;
      SEL_ST:   return {30'b0, md_state};
      default:  return 32'b0;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = dut_val(s);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [31:0] val, input string nm);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic clear_dec();
    reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0; mem_access_d = 0;
    branch_d = 0; alu_src_d = 0; branch_type_d = 0; alu_ctrl_d = 0; md_op_d = 0;
    rd1_d = 0; rd2_d = 0; imm_d = 0; pc_plus4_d = 0; shamt_d = 0;
    write_reg_d = 0; instr_index_d = 0;
  endtask

  // Issue an MD op, track ex_busy each cycle, then read HI and LO back.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_busy, input logic [1:0] st,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    clear_dec();
    md_op_d = op; rd1_d = a; rd2_d = b; reg_write_d = 1; mem_access_d = 1;
    tick();
    expect_out(SEL_BUSY, 1, {nm, " busy first"});
    expect_out(SEL_ST, 0, {nm, " state first"});
    expect_out(SEL_RW, 0, {nm, " reg_write gated"});
    expect_out(SEL_MA, 0, {nm, " mem_access gated"});
    clear_dec();
    alu_ctrl_d = 4'b1101;
    for (int i = 1; i < n_busy; i++) begin
      tick();
      expect_out(SEL_BUSY, 1, {nm, " busy"});
      expect_out(SEL_ST, {30'b0, st}, {nm, " state busy"});
    end
    tick();
    expect_out(SEL_BUSY, 0, {nm, " busy done"});
    expect_out(SEL_ST, 3, {nm, " state done"});
    expect_out(SEL_RW, 1, {nm, " reg_write ungated"});
    tick();
    alu_ctrl_d = 4'b1110;
    expect_out(SEL_ALU, exp_hi, {nm, " HI"});
    expect_out(SEL_ST, 0, {nm, " state idle"});
    tick();
    expect_out(SEL_ALU, exp_lo, {nm, " LO"});
    clear_dec();
  endtask

  // ALU vectors: ctrl, rd1, rd2, imm, alu_src, shamt, expected
  logic [3:0]  t_ctrl [10] = '{4'b0111, 4'b1000, 4'b1011, 4'b1010, 4'b1001,
                               4'b1100, 4'b0100, 4'b0011, 4'b0010, 4'b0101};
  logic [31:0] t_rd1  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0,
                               0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_FFFF, 5};
  logic [31:0] t_rd2  [10] = '{1, 1, 32'h8000_0000, 32'h8000_0000, 3,
                               0, 32'h0F0F_0F00, 32'h0FF0_0FF0, 1, 5};
  logic [31:0] t_imm  [10] = '{0, 0, 0, 0, 0, 32'hFFFF_1234, 0, 0, 0, 0};
  logic        t_src  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic [4:0]  t_sh   [10] = '{0, 0, 4, 4, 31, 0, 0, 0, 0, 0};
  logic [31:0] t_exp  [10] = '{1, 0, 32'hF800_0000, 32'h0800_0000, 32'h8000_0000,
                               32'h1234_0000, 32'h0000_000F, 32'hF0F0_F0F0, 0, 0};

  initial begin
    rst = 1; flush = 0; mem_stall = 0;
    clear_dec();
    tick();
    tick();
    expect_out(SEL_ALU, 0, "reset alu_out");
    expect_out(SEL_ZERO, 1, "reset zero");
    expect_out(SEL_BUSY, 0, "reset busy");
    expect_out(SEL_RW, 0, "reset reg_write");
    expect_out(SEL_MW, 0, "reset mem_write");
    expect_out(SEL_MA, 0, "reset mem_access");
    expect_out(SEL_BR, 0, "reset branch");
    expect_out(SEL_BT, 0, "reset branch_type");
    expect_out(SEL_ST, 0, "reset state");
    rst = 0;

    // ADD 5 + (-3)
    reg_write_d = 1; alu_src_d = 1; alu_ctrl_d = 4'b0010; rd1_d = 5;
    imm_d = 32'hFFFF_FFFD; write_reg_d = 5'd3;
    tick();
    expect_out(SEL_ALU, 2, "add alu_out");
    expect_out(SEL_ZERO, 0, "add zero");
    expect_out(SEL_RW, 1, "add reg_write");
    expect_out(SEL_WR, 3, "add write_reg");

    // BEQ via SUB 7 - 7
    clear_dec();
    alu_ctrl_d = 4'b0110; rd1_d = 7; rd2_d = 7; branch_d = 1;
    branch_type_d = 4'b0100; pc_plus4_d = 32'h100; imm_d = 4;
    tick();
    expect_out(SEL_ALU, 0, "sub alu_out");
    expect_out(SEL_ZERO, 1, "sub zero");
    expect_out(SEL_PCB, 32'h110, "beq pc_branch");
    expect_out(SEL_BR, 1, "beq branch");
    expect_out(SEL_BT, 4, "beq branch_type");
    expect_out(SEL_WD, 7, "beq write_data");

    for (int i = 0; i < 10; i++) begin
      clear_dec();
      alu_ctrl_d = t_ctrl[i]; rd1_d = t_rd1[i]; rd2_d = t_rd2[i];
      imm_d = t_imm[i]; alu_src_d = t_src[i]; shamt_d = t_sh[i];
      tick();
      expect_out(SEL_ALU, t_exp[i], $sformatf("alu table %0d", i));
    end

    // MTHI / MTLO then read back
    clear_dec(); md_op_d = 3'b101; rd1_d = 32'h1234_5678;
    tick();
    expect_out(SEL_BUSY, 0, "mthi busy");
    clear_dec(); md_op_d = 3'b110; rd1_d = 32'h9ABC_DEF0;
    tick();
    clear_dec(); alu_ctrl_d = 4'b1101;
    tick();
    expect_out(SEL_ALU, 32'h1234_5678, "mthi readback");
    alu_ctrl_d = 4'b1110;
    tick();
    expect_out(SEL_ALU, 32'h9ABC_DEF0, "mtlo readback");

    // LW held through a 3-cycle mem_stall; flush during the hold is ignored
    clear_dec();
    reg_write_d = 1; mem_to_reg_d = 1; mem_access_d = 1; alu_src_d = 1;
    alu_ctrl_d = 4'b0010; rd1_d = 32'h1000; imm_d = 8; rd2_d = 32'hDEAD; write_reg_d = 5'd9;
    tick();
    expect_out(SEL_ALU, 32'h1008, "lw alu_out");
    mem_stall = 1;
    clear_dec();
    reg_write_d = 1; alu_src_d = 1; alu_ctrl_d = 4'b0010; rd1_d = 1; imm_d = 1; write_reg_d = 5'd4;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick();
      expect_out(SEL_ALU, 32'h1008, "stall alu_out");
      expect_out(SEL_WD, 32'hDEAD, "stall write_data");
      expect_out(SEL_RW, 1, "stall reg_write");
      expect_out(SEL_MTR, 1, "stall mem_to_reg");
      expect_out(SEL_MA, 1, "stall mem_access");
      expect_out(SEL_WR, 9, "stall write_reg");
    end
    mem_stall = 0; flush = 0;
    tick();
    expect_out(SEL_ALU, 2, "post-stall alu_out");
    expect_out(SEL_WR, 4, "post-stall write_reg");
    expect_out(SEL_MTR, 0, "post-stall mem_to_reg");

    // Flush inserts a bubble
    flush = 1;
    tick();
    flush = 0;
    expect_out(SEL_RW, 0, "flush reg_write");
    expect_out(SEL_ALU, 0, "flush alu_out");
    expect_out(SEL_WR, 0, "flush write_reg");

    // JAL
    clear_dec();
    branch_d = 1; branch_type_d = 4'b0010; pc_plus4_d = 32'h4000_0010;
    instr_index_d = 26'h40; reg_write_d = 1; write_reg_d = 5'd31;
    tick();
    expect_out(SEL_JMP, 32'h4000_0100, "jal jump_addr");
    expect_out(SEL_BT, 2, "jal branch_type");

    run_md(3'b001, 32'hFFFF_FFFE, 3, MUL_CYC + 1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_md(3'b010, 32'hFFFF_FFFF, 2, MUL_CYC + 1, 2'd1, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_md(3'b011, 32'hFFFF_FFF9, 2, 33, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'd2, 32'h0, 32'h8000_0000, "div ovf");
    run_md(3'b100, 10, 0, 33, 2'd2, 32'd10, 32'hFFFF_FFFF, "divu by 0");

    // Reset in the middle of a DIV
    clear_dec(); md_op_d = 3'b011; rd1_d = 100; rd2_d = 7;
    tick();
    repeat (5) tick();
    expect_out(SEL_ST, 2, "pre-reset state");
    rst = 1;
    clear_dec();
    tick();
    rst = 0;
    expect_out(SEL_BUSY, 0, "mid-div reset busy");
    expect_out(SEL_ST, 0, "mid-div reset state");
    alu_ctrl_d = 4'b1101;
    tick();
    expect_out(SEL_ALU, 0, "mid-div reset HI");
    alu_ctrl_d = 4'b1110;
    tick();
    expect_out(SEL_ALU, 0, "mid-div reset LO");

    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
